// File: rtl/load_dat_extract_if.sv
// load_dat_extract_if: request, read-data and writeback bundle for load_dat_extract
//   slave  : the extractor's view (requests/read data in, results out)
//   master : the LSU/memory/writeback side's view
//   iReq*  : load request (valid/ready, addr[1:0], width, unsigned, tag)
//   iRdDat*: in-order memory read responses, no backpressure
//   oLd*   : extracted result to writeback (valid/ready, data, tag, err)
//   oProtErr: sticky flag for read data with nothing pending
interface load_dat_extract_if #(
    parameter int TAG_W = 5
);
    logic             iReqVld;
    logic             oReqRdy;
    logic [1:0]       iReqAddr;
    logic [1:0]       iReqWidth;
    logic             iReqUnsigned;
    logic [TAG_W-1:0] iReqTag;
    logic             iRdDatVld;
    logic [31:0]      iRdDat;
    logic             oLdVld;
    logic             iLdRdy;
    logic [31:0]      oLdDat;
    logic [TAG_W-1:0] oLdTag;
    logic             oLdErr;
    logic             oProtErr;

    modport slave (
        input  iReqVld, iReqAddr, iReqWidth, iReqUnsigned, iReqTag,
        input  iRdDatVld, iRdDat, iLdRdy,
        output oReqRdy, oLdVld, oLdDat, oLdTag, oLdErr, oProtErr
    );

    modport master (
        output iReqVld, iReqAddr, iReqWidth, iReqUnsigned, iReqTag,
        output iRdDatVld, iRdDat, iLdRdy,
        input  oReqRdy, oLdVld, oLdDat, oLdTag, oLdErr, oProtErr
    );
endinterface

// File: rtl/load_dat_extract.sv
// load_dat_extract: in-order outstanding-load tracker with byte/half/word extraction
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : load_dat_extract_if.slave
//         requests are queued in issue order, read words are matched to the
//         oldest entry still awaiting data, and the head result is extracted,
//         sign/zero-extended and offered to writeback over valid/ready.
module load_dat_extract #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input logic                clk,
    input logic                rst,
    load_dat_extract_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    ptr_t             r_wr_ptr;
    ptr_t             r_rsp_ptr;
    ptr_t             r_rd_ptr;
    logic             r_prot_err;
    logic [1:0]       r_addr  [DEPTH];
    logic [1:0]       r_width [DEPTH];
    logic             r_uns   [DEPTH];
    logic [TAG_W-1:0] r_tag   [DEPTH];
    logic             r_err   [DEPTH];
    logic [31:0]      r_dat   [DEPTH];
    logic             r_done  [DEPTH];

    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rsp_idx;
    logic [AW-1:0]    w_rd_idx;
    ptr_t             w_used;
    logic             w_req_rdy;
    logic             w_acc;
    logic             w_rsp_pend;
    logic             w_rsp_ok;
    logic             w_rsp_drop;
    logic             w_ld_vld;
    logic             w_pop;
    logic             w_req_err;
    logic [1:0]       w_h_addr;
    logic [1:0]       w_h_width;
    logic             w_h_uns;
    logic [31:0]      w_h_dat;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ext;

    assign w_wr_idx  = r_wr_ptr[AW-1:0];
    assign w_rsp_idx = r_rsp_ptr[AW-1:0];
    assign w_rd_idx  = r_rd_ptr[AW-1:0];

    // Occupancy uses registered pointers only; a pop this cycle frees its slot next cycle.
    assign w_used     = r_wr_ptr - r_rd_ptr;
    assign w_req_rdy  = w_used < ptr_t'(DEPTH);
    assign w_acc      = bus.iReqVld & w_req_rdy;
    assign w_rsp_pend = r_rsp_ptr != r_wr_ptr;
    assign w_rsp_ok   = bus.iRdDatVld & w_rsp_pend;
    assign w_rsp_drop = bus.iRdDatVld & ~w_rsp_pend;
    // Head is ready once the response pointer has moved past it; done mirrors that.
    assign w_ld_vld   = (r_rd_ptr != r_rsp_ptr) & r_done[w_rd_idx];
    assign w_pop      = w_ld_vld & bus.iLdRdy;

    assign w_req_err = (bus.iReqWidth == 2'd1 & bus.iReqAddr[0]) |
                       (bus.iReqWidth == 2'd2 & bus.iReqAddr != 2'd0) |
                       (bus.iReqWidth == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rsp_ptr  <= '0;
            r_rd_ptr   <= '0;
            r_prot_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_done[i] <= 1'b0;
        end else begin
            if (w_acc) begin
                r_wr_ptr         <= r_wr_ptr + ptr_t'(1);
                r_done[w_wr_idx] <= 1'b0;
            end
            if (w_rsp_ok) begin
                r_rsp_ptr         <= r_rsp_ptr + ptr_t'(1);
                r_done[w_rsp_idx] <= 1'b1;
            end
            if (w_rsp_drop) r_prot_err <= 1'b1;
            if (w_pop) begin
                r_rd_ptr         <= r_rd_ptr + ptr_t'(1);
                r_done[w_rd_idx] <= 1'b0;
            end
        end
    end

    // Payload needs no reset: it is only observed through pointer-qualified valids.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_addr[w_wr_idx]  <= bus.iReqAddr;
            r_width[w_wr_idx] <= bus.iReqWidth;
            r_uns[w_wr_idx]   <= bus.iReqUnsigned;
            r_tag[w_wr_idx]   <= bus.iReqTag;
            r_err[w_wr_idx]   <= w_req_err;
        end
        if (w_rsp_ok) r_dat[w_rsp_idx] <= bus.iRdDat;
    end

    assign w_h_addr  = r_addr[w_rd_idx];
    assign w_h_width = r_width[w_rd_idx];
    assign w_h_uns   = r_uns[w_rd_idx];
    assign w_h_dat   = r_dat[w_rd_idx];

    // Half select ignores addr[0]; word and reserved widths pass the whole word through.
    always_comb begin
        w_byte = w_h_dat[8*w_h_addr +: 8];
        w_half = w_h_dat[16*w_h_addr[1] +: 16];
        w_ext  = (w_h_width == 2'd0) ? {{24{~w_h_uns & w_byte[7]}}, w_byte} :
                 (w_h_width == 2'd1) ? {{16{~w_h_uns & w_half[15]}}, w_half} :
                 w_h_dat;
    end

    assign bus.oReqRdy  = w_req_rdy;
    assign bus.oLdVld   = w_ld_vld;
    assign bus.oLdDat   = w_ext;
    assign bus.oLdTag   = r_tag[w_rd_idx];
    assign bus.oLdErr   = w_ld_vld & r_err[w_rd_idx];
    assign bus.oProtErr = r_prot_err;
endmodule

// File: tb/tb_load_dat_extract.sv
// tb_load_dat_extract: directed self-checking bench for load_dat_extract
module tb_load_dat_extract;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    load_dat_extract_if #(.TAG_W(5)) bus ();

    load_dat_extract #(.DEPTH(4), .TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] a, input logic [1:0] w, input logic u, input logic [4:0] t);
        bus.iReqVld      = 1'b1;
        bus.iReqAddr     = a;
        bus.iReqWidth    = w;
        bus.iReqUnsigned = u;
        bus.iReqTag      = t;
        tick();
        bus.iReqVld      = 1'b0;
    endtask

    task automatic resp(input logic [31:0] d);
        bus.iRdDatVld = 1'b1;
        bus.iRdDat    = d;
        tick();
        bus.iRdDatVld = 1'b0;
    endtask

    task automatic pop();
        bus.iLdRdy = 1'b1;
        tick();
        bus.iLdRdy = 1'b0;
    endtask

    task automatic expect_ld(input string tag, input logic [31:0] d, input logic [4:0] t, input logic e);
        check({tag, "_vld"}, {31'd0, bus.oLdVld}, 32'd1);
        check({tag, "_dat"}, bus.oLdDat, d);
        check({tag, "_tag"}, {27'd0, bus.oLdTag}, {27'd0, t});
        check({tag, "_err"}, {31'd0, bus.oLdErr}, {31'd0, e});
    endtask

    initial begin
        rst              = 1'b1;
        bus.iReqVld      = 1'b0;
        bus.iReqAddr     = 2'd0;
        bus.iReqWidth    = 2'd0;
        bus.iReqUnsigned = 1'b0;
        bus.iReqTag      = 5'd0;
        bus.iRdDatVld    = 1'b0;
        bus.iRdDat       = 32'd0;
        bus.iLdRdy       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_rdy",  {31'd0, bus.oReqRdy},  32'd1);
        check("rst_vld",  {31'd0, bus.oLdVld},   32'd0);
        check("rst_err",  {31'd0, bus.oLdErr},   32'd0);
        check("rst_prot", {31'd0, bus.oProtErr}, 32'd0);

        issue(2'd3, 2'd0, 1'b0, 5'd7);
        check("sb_pre_vld", {31'd0, bus.oLdVld}, 32'd0);
        bus.iRdDatVld = 1'b1;
        bus.iRdDat    = 32'h80FF_1234;
        check("sb_same_vld", {31'd0, bus.oLdVld}, 32'd0);
        tick();
        bus.iRdDatVld = 1'b0;
        expect_ld("sbyte", 32'hFFFF_FF80, 5'd7, 1'b0);
        pop();
        check("sb_pop_vld", {31'd0, bus.oLdVld}, 32'd0);

        issue(2'd1, 2'd0, 1'b1, 5'd8);
        resp(32'h80FF_1234);
        expect_ld("ubyte1", 32'h0000_0012, 5'd8, 1'b0);
        pop();

        issue(2'd2, 2'd1, 1'b1, 5'd1);
        resp(32'h9ABC_0001);
        expect_ld("uhalf", 32'h0000_9ABC, 5'd1, 1'b0);
        pop();
        issue(2'd2, 2'd1, 1'b0, 5'd2);
        resp(32'h9ABC_0001);
        expect_ld("shalf", 32'hFFFF_9ABC, 5'd2, 1'b0);
        pop();
        issue(2'd3, 2'd1, 1'b0, 5'd4);
        resp(32'h9ABC_0001);
        expect_ld("mhalf", 32'hFFFF_9ABC, 5'd4, 1'b1);
        pop();
        issue(2'd0, 2'd2, 1'b0, 5'd3);
        resp(32'h9ABC_0001);
        expect_ld("word", 32'h9ABC_0001, 5'd3, 1'b0);
        pop();

        for (int i = 1; i <= 4; i++) begin
            check("fill_rdy", {31'd0, bus.oReqRdy}, 32'd1);
            issue(2'd0, 2'd2, 1'b0, 5'(i));
        end
        check("full_rdy", {31'd0, bus.oReqRdy}, 32'd0);
        issue(2'd0, 2'd2, 1'b0, 5'd9);
        check("full_vld", {31'd0, bus.oLdVld}, 32'd0);
        for (int i = 1; i <= 3; i++) resp(32'h1000_0000 + 32'(i));
        expect_ld("head_hold", 32'h1000_0001, 5'd1, 1'b0);
        tick();
        expect_ld("head_hold2", 32'h1000_0001, 5'd1, 1'b0);
        bus.iRdDatVld    = 1'b1;
        bus.iRdDat       = 32'h1000_0004;
        bus.iLdRdy       = 1'b1;
        bus.iReqVld      = 1'b1;
        bus.iReqTag      = 5'd9;
        check("pop_full_rdy", {31'd0, bus.oReqRdy}, 32'd0);
        tick();
        bus.iRdDatVld = 1'b0;
        bus.iReqVld   = 1'b0;
        check("after_pop_rdy", {31'd0, bus.oReqRdy}, 32'd1);
        for (int i = 2; i <= 4; i++) begin
            expect_ld("drain", 32'h1000_0000 + 32'(i), 5'(i), 1'b0);
            tick();
        end
        bus.iLdRdy = 1'b0;
        check("drain_vld", {31'd0, bus.oLdVld}, 32'd0);

        issue(2'd1, 2'd2, 1'b0, 5'd5);
        check("mis_rdy", {31'd0, bus.oReqRdy}, 32'd1);
        resp(32'h1122_3344);
        expect_ld("misword", 32'h1122_3344, 5'd5, 1'b1);
        pop();
        issue(2'd0, 2'd3, 1'b1, 5'd6);
        resp(32'hCAFE_F00D);
        expect_ld("resw", 32'hCAFE_F00D, 5'd6, 1'b1);
        pop();

        check("pre_prot", {31'd0, bus.oProtErr}, 32'd0);
        resp(32'hDEAD_BEEF);
        check("prot_set", {31'd0, bus.oProtErr}, 32'd1);
        check("prot_vld", {31'd0, bus.oLdVld},   32'd0);
        tick();
        tick();
        check("prot_hold", {31'd0, bus.oProtErr}, 32'd1);

        issue(2'd0, 2'd2, 1'b0, 5'd12);
        issue(2'd0, 2'd2, 1'b0, 5'd13);
        resp(32'h0000_0012);
        check("mid_vld", {31'd0, bus.oLdVld}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_vld",  {31'd0, bus.oLdVld},   32'd0);
        check("mrst_rdy",  {31'd0, bus.oReqRdy},  32'd1);
        check("mrst_prot", {31'd0, bus.oProtErr}, 32'd0);
        issue(2'd1, 2'd0, 1'b0, 5'd14);
        resp(32'h0000_7F00);
        expect_ld("post_rst", 32'h0000_007F, 5'd14, 1'b0);
        pop();
        check("post_rst_vld", {31'd0, bus.oLdVld}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
